cart_mem_arbiter: RTL and testbench

Downstream stage of the cartridge mappers: takes the translated PRG (CPU) and CHR (PPU) byte accesses that the active mapper drives onto the shared `prg_aout`/`chr_aout` buses and serialises them onto the single cart memory port. Each side has a one-deep request slot. A round-robin grant FSM runs a req/ack handshake with the memory controller. Returned read data is held per side. Accesses the mapper does not allow are filtered here: reads return open-bus `8'hFF` without touching memory, and writes are dropped.

---
 rtl/cart_mem_arbiter_if.sv | 31 +++
 rtl/cart_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_mem_arbiter_if.sv
// Cart memory port: request/acknowledge handshake between the arbiter and the memory controller.
interface cart_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 22
);
   localparam int unsigned DATA_W = 8;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Serialises mapper PRG (CPU) and CHR (PPU) byte accesses onto the single cart memory port.
// Each side owns a one-deep request slot; a round-robin grant FSM runs the memory handshake.
// Accesses the mapper disallows never reach memory: reads return open bus, writes vanish.
module cart_mem_arbiter #(
   parameter int unsigned ADDR_W = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] prg_addr,
   input  logic              prg_read,
   input  logic              prg_write,
   input  logic              prg_allow,
   input  logic [7:0]        prg_din,
   output logic [7:0]        prg_dout,
   output logic              prg_busy,
   input  logic [ADDR_W-1:0] chr_addr,
   input  logic              chr_read,
   input  logic              chr_write,
   input  logic              chr_allow,
   input  logic [7:0]        chr_din,
   output logic [7:0]        chr_dout,
   output logic              chr_busy,
   cart_mem_arbiter_if.master mem,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;
   typedef enum logic {SIDE_PRG, SIDE_CHR} side_t;

   typedef struct packed {
      logic              busy;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } slot_t;

   state_t            state_q, state_d;
   side_t             last_grant_q, last_grant_d;
   side_t             grant;
   slot_t             prg_slot_q, prg_slot_d;
   slot_t             chr_slot_q, chr_slot_d;
   logic [DATA_W-1:0] prg_dout_q, prg_dout_d;
   logic [DATA_W-1:0] chr_dout_q, chr_dout_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              prg_strobe, chr_strobe;
   logic              prg_drop, chr_drop;
   logic [CNT_W:0]    drop_sum;

   // State register and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= SIDE_CHR;
         prg_slot_q   <= '0;
         chr_slot_q   <= '0;
         prg_dout_q   <= OPEN_BUS;
         chr_dout_q   <= OPEN_BUS;
         drop_cnt_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         prg_slot_q   <= prg_slot_d;
         chr_slot_q   <= chr_slot_d;
         prg_dout_q   <= prg_dout_d;
         chr_dout_q   <= chr_dout_d;
         drop_cnt_q   <= drop_cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Slot capture, access filtering, drop counting and grant/handshake next-state
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant        = SIDE_PRG;
      prg_slot_d   = prg_slot_q;
      chr_slot_d   = chr_slot_q;
      prg_dout_d   = prg_dout_q;
      chr_dout_d   = chr_dout_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;

      // A strobe landing on an occupied slot is lost, even if that slot completes this cycle
      prg_strobe = prg_read | prg_write;
      chr_strobe = chr_read | chr_write;
      prg_drop   = prg_strobe & prg_slot_q.busy;
      chr_drop   = chr_strobe & chr_slot_q.busy;

      // read+write together is a write; a denied read answers open bus immediately
      if (prg_strobe && !prg_slot_q.busy) begin
         if (prg_allow) begin
            prg_slot_d = '{busy: 1'b1, we: prg_write, addr: prg_addr, wdata: prg_din};
         end else if (!prg_write) begin
            prg_dout_d = OPEN_BUS;
         end
      end
      if (chr_strobe && !chr_slot_q.busy) begin
         if (chr_allow) begin
            chr_slot_d = '{busy: 1'b1, we: chr_write, addr: chr_addr, wdata: chr_din};
         end else if (!chr_write) begin
            chr_dout_d = OPEN_BUS;
         end
      end

      drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(prg_drop) + (CNT_W+1)'(chr_drop);
      drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

      case (state_q)
         ST_IDLE: begin
            if (prg_slot_q.busy || chr_slot_q.busy) begin
               if (prg_slot_q.busy && chr_slot_q.busy) begin
                  grant = (last_grant_q == SIDE_PRG) ? SIDE_CHR : SIDE_PRG;
               end else begin
                  grant = prg_slot_q.busy ? SIDE_PRG : SIDE_CHR;
               end
               last_grant_d = grant;
               state_d      = ST_WAIT;
               mem_req_d    = 1'b1;
               if (grant == SIDE_PRG) begin
                  mem_we_d    = prg_slot_q.we;
                  mem_addr_d  = prg_slot_q.addr;
                  mem_wdata_d = prg_slot_q.wdata;
               end else begin
                  mem_we_d    = chr_slot_q.we;
                  mem_addr_d  = chr_slot_q.addr;
                  mem_wdata_d = chr_slot_q.wdata;
               end
            end
         end
         ST_WAIT: begin
            // last_grant_q names the side whose access is in flight
            if (mem.mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
               if (last_grant_q == SIDE_PRG) begin
                  prg_slot_d.busy = 1'b0;
                  if (!mem_we_q) prg_dout_d = mem.mem_rdata;
               end else begin
                  chr_slot_d.busy = 1'b0;
                  if (!mem_we_q) chr_dout_d = mem.mem_rdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign prg_dout      = prg_dout_q;
   assign prg_busy      = prg_slot_q.busy;
   assign chr_dout      = chr_dout_q;
   assign chr_busy      = chr_slot_q.busy;
   assign drop_cnt      = drop_cnt_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus a randomized phase against a
// transaction-level reference (expected memory transaction list, per-side read data, drop total).
module tb_cart_mem_arbiter;

   localparam int unsigned ADDR_W = 22;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wdata;
   } txn_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] prg_addr, chr_addr;
   logic              prg_read, prg_write, prg_allow;
   logic              chr_read, chr_write, chr_allow;
   logic [7:0]        prg_din, chr_din, prg_dout, chr_dout, drop_cnt;
   logic              prg_busy, chr_busy;

   cart_mem_arbiter_if #(.ADDR_W(ADDR_W)) mem_if ();

   cart_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .prg_addr(prg_addr), .prg_read(prg_read), .prg_write(prg_write), .prg_allow(prg_allow),
      .prg_din(prg_din), .prg_dout(prg_dout), .prg_busy(prg_busy),
      .chr_addr(chr_addr), .chr_read(chr_read), .chr_write(chr_write), .chr_allow(chr_allow),
      .chr_din(chr_din), .chr_dout(chr_dout), .chr_busy(chr_busy),
      .mem(mem_if), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail   = 0;
   txn_t mon_q[$];
   logic resp_en = 1'b0;
   int   resp_lat = 1;
   logic force_en = 1'b0;
   logic [7:0] force_val = 8'h00;
   int   kick_cnt = 0;

   function automatic logic [7:0] rd_fn(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_prg(input logic rd, input logic wr, input logic al,
                          input logic [ADDR_W-1:0] a, input logic [7:0] d);
      prg_read = rd; prg_write = wr; prg_allow = al; prg_addr = a; prg_din = d;
   endtask

   task automatic set_chr(input logic rd, input logic wr, input logic al,
                          input logic [ADDR_W-1:0] a, input logic [7:0] d);
      chr_read = rd; chr_write = wr; chr_allow = al; chr_addr = a; chr_din = d;
   endtask

   task automatic idle_strobes();
      prg_read = 1'b0; prg_write = 1'b0; chr_read = 1'b0; chr_write = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Waits (bounded) until both slots drain and the port is idle
   task automatic wait_quiet(input string tag, input int budget);
      int n;
      n = 0;
      while ((prg_busy || chr_busy || mem_if.mem_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < budget), 32'(1));
   endtask

   // Memory model: records each request, checks it is held, acks after a latency
   initial begin : responder
      txn_t t;
      int   lat;
      int   kick_seen;
      kick_seen = 0;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (kick_cnt != kick_seen) begin
            kick_seen        = kick_cnt;
            mem_if.mem_rdata = 8'h55;
            mem_if.mem_ack   = 1'b1;
            @(negedge clk);
            mem_if.mem_ack   = 1'b0;
         end else if (resp_en && mem_if.mem_req) begin
            t = '{we: mem_if.mem_we, addr: mem_if.mem_addr, wdata: mem_if.mem_wdata};
            mon_q.push_back(t);
            lat = (resp_lat != 0) ? resp_lat : int'($urandom_range(1, 4));
            repeat (lat - 1) begin
               @(negedge clk);
               chk("hold_req", 32'(mem_if.mem_req), 32'(1));
               chk("hold_addr", 32'(mem_if.mem_addr), 32'(t.addr));
            end
            mem_if.mem_rdata = force_en ? force_val : rd_fn(t.addr);
            mem_if.mem_ack   = 1'b1;
            @(negedge clk);
            mem_if.mem_ack   = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [ADDR_W-1:0] pa, ca, p_rr [2], c_rr [2];
      logic [7:0]        pdat, cdat, exp_pd, exp_cd;
      int                exp_drop, np, nc, pop, cop, n;
      logic              mg_chr, p_cap, c_cap;
      txn_t              exp_q[$];
      txn_t              pt, ct;

      reset = 1'b1;
      set_prg(0, 0, 0, '0, '0);
      set_chr(0, 0, 0, '0, '0);
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_mem_req", 32'(mem_if.mem_req), 32'(0));
      chk("rst_mem_we", 32'(mem_if.mem_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_if.mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_if.mem_wdata), 32'(0));
      chk("rst_prg_dout", 32'(prg_dout), 32'hFF);
      chk("rst_chr_dout", 32'(chr_dout), 32'hFF);
      chk("rst_busy", 32'({prg_busy, chr_busy}), 32'(0));
      chk("rst_drop", 32'(drop_cnt), 32'(0));
      reset = 1'b0;
      @(negedge clk);

      // PRG read, memory acks three cycles after the request
      resp_en = 1'b1; resp_lat = 3; force_en = 1'b1; force_val = 8'hA5;
      mon_q.delete();
      set_prg(1, 0, 1, 22'h012345, 8'h00);
      @(negedge clk);
      idle_strobes();
      chk("t1_busy_e0", 32'(prg_busy), 32'(1));
      chk("t1_req_e0", 32'(mem_if.mem_req), 32'(0));
      @(negedge clk);
      chk("t1_req_e1", 32'(mem_if.mem_req), 32'(1));
      chk("t1_addr", 32'(mem_if.mem_addr), 32'h012345);
      chk("t1_we", 32'(mem_if.mem_we), 32'(0));
      repeat (2) @(negedge clk);
      chk("t1_busy_e3", 32'(prg_busy), 32'(1));
      chk("t1_dout_e3", 32'(prg_dout), 32'hFF);
      @(negedge clk);
      chk("t1_dout_e4", 32'(prg_dout), 32'hA5);
      chk("t1_busy_e4", 32'(prg_busy), 32'(0));
      chk("t1_req_e4", 32'(mem_if.mem_req), 32'(0));
      chk("t1_ntxn", 32'(mon_q.size()), 32'(1));
      force_en = 1'b0;

      // Simultaneous PRG read and CHR write after reset: PRG first, one idle cycle, then CHR
      pulse_reset();
      resp_lat = 1;
      mon_q.delete();
      set_prg(1, 0, 1, 22'h0ABCDE, 8'h00);
      set_chr(0, 1, 1, 22'h155AA0, 8'h3C);
      @(negedge clk);
      idle_strobes();
      chk("t2_busy_both", 32'({prg_busy, chr_busy}), 32'b11);
      @(negedge clk);
      chk("t2_req_prg", 32'(mem_if.mem_req), 32'(1));
      chk("t2_addr_prg", 32'(mem_if.mem_addr), 32'h0ABCDE);
      chk("t2_we_prg", 32'(mem_if.mem_we), 32'(0));
      @(negedge clk);
      chk("t2_req_gap", 32'(mem_if.mem_req), 32'(0));
      chk("t2_busy_mid", 32'({prg_busy, chr_busy}), 32'b01);
      chk("t2_prg_dout", 32'(prg_dout), 32'(rd_fn(22'h0ABCDE)));
      @(negedge clk);
      chk("t2_req_chr", 32'(mem_if.mem_req), 32'(1));
      chk("t2_we_chr", 32'(mem_if.mem_we), 32'(1));
      chk("t2_addr_chr", 32'(mem_if.mem_addr), 32'h155AA0);
      chk("t2_wdata_chr", 32'(mem_if.mem_wdata), 32'h3C);
      @(negedge clk);
      chk("t2_chr_busy", 32'(chr_busy), 32'(0));
      chk("t2_chr_dout", 32'(chr_dout), 32'hFF);

      // Round-robin with both slots kept busy
      resp_lat = 2;
      mon_q.delete();
      p_rr[0] = 22'h001111; p_rr[1] = 22'h002222;
      c_rr[0] = 22'h203333; c_rr[1] = 22'h204444;
      set_prg(1, 0, 1, p_rr[0], 8'h00);
      set_chr(1, 0, 1, c_rr[0], 8'h00);
      np = 1; nc = 1; n = 0;
      while (mon_q.size() < 4 && n < 100) begin
         @(negedge clk);
         idle_strobes();
         n++;
         if (!prg_busy && np < 2) begin set_prg(1, 0, 1, p_rr[np], 8'h00); np++; end
         if (!chr_busy && nc < 2) begin set_chr(1, 0, 1, c_rr[nc], 8'h00); nc++; end
      end
      wait_quiet("t3_timeout", 40);
      chk("t3_ntxn", 32'(mon_q.size()), 32'(4));
      if (mon_q.size() == 4) begin
         chk("t3_order0", 32'(mon_q[0].addr), 32'(p_rr[0]));
         chk("t3_order1", 32'(mon_q[1].addr), 32'(c_rr[0]));
         chk("t3_order2", 32'(mon_q[2].addr), 32'(p_rr[1]));
         chk("t3_order3", 32'(mon_q[3].addr), 32'(c_rr[1]));
      end
      chk("t3_prg_dout", 32'(prg_dout), 32'(rd_fn(p_rr[1])));
      chk("t3_chr_dout", 32'(chr_dout), 32'(rd_fn(c_rr[1])));

      // Filtering: denied read answers open bus, denied write vanishes
      mon_q.delete();
      set_prg(1, 0, 0, 22'h3FFFFF, 8'h00);
      @(negedge clk);
      idle_strobes();
      chk("t4_prg_dout_ff", 32'(prg_dout), 32'hFF);
      chk("t4_prg_busy", 32'(prg_busy), 32'(0));
      set_chr(0, 1, 0, 22'h000777, 8'h77);
      @(negedge clk);
      idle_strobes();
      chk("t4_chr_busy", 32'(chr_busy), 32'(0));
      repeat (2) @(negedge clk);
      chk("t4_no_req", 32'(mem_if.mem_req), 32'(0));
      chk("t4_chr_busy_late", 32'(chr_busy), 32'(0));
      chk("t4_no_txn", 32'(mon_q.size()), 32'(0));
      chk("t4_chr_dout_kept", 32'(chr_dout), 32'(rd_fn(c_rr[1])));

      // read+write together is a write
      set_prg(1, 1, 1, 22'h0C0DE0, 8'h9E);
      @(negedge clk);
      idle_strobes();
      wait_quiet("t4_rw_timeout", 20);
      chk("t4_rw_ntxn", 32'(mon_q.size()), 32'(1));
      if (mon_q.size() == 1) begin
         chk("t4_rw_we", 32'(mon_q[0].we), 32'(1));
         chk("t4_rw_wdata", 32'(mon_q[0].wdata), 32'h9E);
      end
      chk("t4_rw_dout", 32'(prg_dout), 32'hFF);

      // Drops: busy strobe counted, single memory transaction
      pulse_reset();
      mon_q.delete();
      set_prg(1, 0, 1, 22'h010101, 8'h00);
      @(negedge clk);
      set_prg(1, 0, 1, 22'h020202, 8'h00);
      @(negedge clk);
      idle_strobes();
      chk("t5_drop1", 32'(drop_cnt), 32'(1));
      wait_quiet("t5_timeout", 20);
      chk("t5_ntxn", 32'(mon_q.size()), 32'(1));
      if (mon_q.size() == 1) chk("t5_addr", 32'(mon_q[0].addr), 32'h010101);

      // Both sides dropping together, then saturation
      resp_en = 1'b0;
      set_prg(1, 0, 1, 22'h030303, 8'h00);
      set_chr(1, 0, 1, 22'h040404, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("t5_drop3", 32'(drop_cnt), 32'(3));
      repeat (150) @(negedge clk);
      idle_strobes();
      chk("t5_drop_sat", 32'(drop_cnt), 32'(255));

      // Reset mid-transaction, then a stray ack
      chk("t6_req_wait", 32'(mem_if.mem_req), 32'(1));
      reset = 1'b1;
      #1;
      chk("t6_req_async", 32'(mem_if.mem_req), 32'(0));
      chk("t6_busy_async", 32'({prg_busy, chr_busy}), 32'(0));
      chk("t6_drop_async", 32'(drop_cnt), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      kick_cnt++;
      repeat (3) @(negedge clk);
      chk("t6_prg_dout", 32'(prg_dout), 32'hFF);
      chk("t6_chr_dout", 32'(chr_dout), 32'hFF);
      chk("t6_busy", 32'({prg_busy, chr_busy}), 32'(0));
      chk("t6_req", 32'(mem_if.mem_req), 32'(0));

      // Randomized phase against transaction-level reference
      pulse_reset();
      resp_en = 1'b1; resp_lat = 0;
      mg_chr = 1'b1; exp_pd = 8'hFF; exp_cd = 8'hFF; exp_drop = 0;
      for (int it = 0; it < 40; it++) begin
         mon_q.delete();
         exp_q.delete();
         pop = int'($urandom_range(0, 5));
         cop = int'($urandom_range(0, 5));
         pa = ADDR_W'($urandom); ca = ADDR_W'($urandom);
         pdat = 8'($urandom); cdat = 8'($urandom);
         set_prg(pop == 1 || pop == 3 || pop == 5, pop == 2 || pop == 4 || pop == 5,
                 pop == 1 || pop == 2 || pop == 5, pa, pdat);
         set_chr(cop == 1 || cop == 3 || cop == 5, cop == 2 || cop == 4 || cop == 5,
                 cop == 1 || cop == 2 || cop == 5, ca, cdat);
         p_cap = (pop == 1 || pop == 2 || pop == 5);
         c_cap = (cop == 1 || cop == 2 || cop == 5);
         pt = '{we: (pop != 1), addr: pa, wdata: pdat};
         ct = '{we: (cop != 1), addr: ca, wdata: cdat};
         if (pop == 1) exp_pd = rd_fn(pa);
         if (pop == 3) exp_pd = 8'hFF;
         if (cop == 1) exp_cd = rd_fn(ca);
         if (cop == 3) exp_cd = 8'hFF;
         @(negedge clk);
         idle_strobes();
         if (p_cap && $urandom_range(0, 1) == 1) begin
            set_prg(1, 0, 1, ADDR_W'($urandom), 8'($urandom)); exp_drop++;
         end
         if (c_cap && $urandom_range(0, 1) == 1) begin
            set_chr(0, 1, 1, ADDR_W'($urandom), 8'($urandom)); exp_drop++;
         end
         @(negedge clk);
         idle_strobes();
         if (p_cap && c_cap) begin
            if (mg_chr) begin exp_q.push_back(pt); exp_q.push_back(ct); mg_chr = 1'b1; end
            else begin exp_q.push_back(ct); exp_q.push_back(pt); mg_chr = 1'b0; end
         end else if (p_cap) begin
            exp_q.push_back(pt); mg_chr = 1'b0;
         end else if (c_cap) begin
            exp_q.push_back(ct); mg_chr = 1'b1;
         end
         wait_quiet("rnd_timeout", 40);
         chk("rnd_ntxn", 32'(mon_q.size()), 32'(exp_q.size()));
         for (int k = 0; k < exp_q.size(); k++) begin
            if (k < mon_q.size()) begin
               chk("rnd_addr", 32'(mon_q[k].addr), 32'(exp_q[k].addr));
               chk("rnd_we", 32'(mon_q[k].we), 32'(exp_q[k].we));
               if (exp_q[k].we) chk("rnd_wdata", 32'(mon_q[k].wdata), 32'(exp_q[k].wdata));
            end
         end
         chk("rnd_prg_dout", 32'(prg_dout), 32'(exp_pd));
         chk("rnd_chr_dout", 32'(chr_dout), 32'(exp_cd));
         chk("rnd_drop", 32'(drop_cnt), 32'((exp_drop > 255) ? 255 : exp_drop));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
